// File: rtl/dp_ram_be_if.sv
// Request/return bundle for one port of the dual-port byte-enable RAM.
interface dp_ram_be_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic                  en;
  logic                  we;
  logic [NUM_BYTES-1:0]  be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rvalid;

  modport master (output en, we, be, addr, din, input dout, rvalid);
  modport slave  (input en, we, be, addr, din, output dout, rvalid);
endinterface

// File: rtl/dp_ram_be.sv
// True dual-port synchronous RAM with byte enables, 1/2-cycle read latency,
// selectable same-port write return, port-A-wins collision merge and an
// optional post-reset clear engine.
module dp_ram_be #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         rst,
  dp_ram_be_if.slave   port_a,
  dp_ram_be_if.slave   port_b,
  output logic         init_busy,
  output logic         collision
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_busy_q;
  logic                  collision_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, ret_a, ret_b;
  logic                  pv_a, pv_b;
  logic [DATA_WIDTH-1:0] pd_a, pd_b;
  logic                  rvalid_a_q, rvalid_b_q;
  logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;

  assign acc_a     = port_a.en && (state_q == ST_RUN);
  assign acc_b     = port_b.en && (state_q == ST_RUN);
  assign wr_a      = acc_a && port_a.we;
  assign wr_b      = acc_b && port_b.we;
  assign same_addr = (port_a.addr == port_b.addr);
  assign old_a     = mem[port_a.addr];
  assign old_b     = mem[port_b.addr];

  // Post-write word seen at each port's address: B lanes first, then A lanes so A wins overlaps.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (wr_b && same_addr && port_b.be[i]) new_a[8*i +: 8] = port_b.din[8*i +: 8];
      if (port_a.be[i])                      new_a[8*i +: 8] = port_a.din[8*i +: 8];
      if (port_b.be[i])                      new_b[8*i +: 8] = port_b.din[8*i +: 8];
      if (wr_a && same_addr && port_a.be[i]) new_b[8*i +: 8] = port_a.din[8*i +: 8];
    end
    ret_a = (port_a.we && (WRITE_FIRST != 0)) ? new_a : old_a;
    ret_b = (port_b.we && (WRITE_FIRST != 0)) ? new_b : old_b;
  end

  // Array update: clear sweep, or per-lane writes with port A issued last so it wins collisions.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wr_b && port_b.be[i]) mem[port_b.addr][8*i +: 8] <= port_b.din[8*i +: 8];
      end
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wr_a && port_a.be[i]) mem[port_a.addr][8*i +: 8] <= port_a.din[8*i +: 8];
      end
    end
  end

  // Control FSM: clear sweep then run; also registers init_busy and the collision pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
      collision_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          init_busy_q <= 1'b0;
        end
      endcase
      collision_q <= wr_a && wr_b && same_addr && (|(port_a.be & port_b.be));
    end
  end

  // Optional extra pipeline stage between array access and the output registers.
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_a_q, s1_valid_b_q;
    logic [DATA_WIDTH-1:0] s1_data_a_q, s1_data_b_q;

    // First return stage; flushed by reset so in-flight requests are dropped.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_a_q <= 1'b0;
        s1_valid_b_q <= 1'b0;
        s1_data_a_q  <= '0;
        s1_data_b_q  <= '0;
      end else begin
        s1_valid_a_q <= acc_a;
        s1_valid_b_q <= acc_b;
        s1_data_a_q  <= ret_a;
        s1_data_b_q  <= ret_b;
      end
    end

    assign pv_a = s1_valid_a_q;
    assign pv_b = s1_valid_b_q;
    assign pd_a = s1_data_a_q;
    assign pd_b = s1_data_b_q;
  end else begin : g_lat1
    assign pv_a = acc_a;
    assign pv_b = acc_b;
    assign pd_a = ret_a;
    assign pd_b = ret_b;
  end

  // Output registers: dout only moves on a valid return, otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      dout_a_q   <= '0;
      dout_b_q   <= '0;
    end else begin
      rvalid_a_q <= pv_a;
      rvalid_b_q <= pv_b;
      if (pv_a) dout_a_q <= pd_a;
      if (pv_b) dout_b_q <= pd_b;
    end
  end

  assign port_a.dout   = dout_a_q;
  assign port_a.rvalid = rvalid_a_q;
  assign port_b.dout   = dout_b_q;
  assign port_b.rvalid = rvalid_b_q;
  assign init_busy     = init_busy_q;
  assign collision     = collision_q;
endmodule
